serial_frame_capture: RTL

//  Parametrised serial-to-parallel capture for the display shift chain (serial data/clk/latch).

---
 rtl/serial_frame_capture.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_frame_capture.sv
// Serial-to-parallel capture of a data/clk/latch shift chain, all sampled in i_clk.
// Commits correctly sized frames on the latch edge and flags short or overlong ones.
module serial_frame_capture #(
    parameter int SHIFT_WIDTH  = 48,
    parameter int MSB_FIRST    = 1,
    parameter int SYNC_STAGES  = 2,
    parameter int CHECK_LENGTH = 1,
    parameter int FCOUNT_WIDTH = 8,
    localparam int CW          = $clog2(SHIFT_WIDTH + 2)
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_en,
    input  logic                    i_serial_data,
    input  logic                    i_serial_clk,
    input  logic                    i_serial_latch,
    output logic [SHIFT_WIDTH-1:0]  o_parallel_data,
    output logic                    o_valid,
    output logic                    o_frame_err,
    output logic [CW-1:0]           o_bit_count,
    output logic [FCOUNT_WIDTH-1:0] o_frame_count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(SHIFT_WIDTH);
    localparam logic [CW-1:0] MAX_CNT  = CW'(SHIFT_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, OVER} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync_d, r_sync_c, r_sync_l;
    logic                   r_clk_q, r_lat_q;
    logic [SHIFT_WIDTH-1:0] r_shift;

    logic                   w_data, w_clk_rise, w_lat_rise, w_commit;
    logic [SHIFT_WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]          w_count_nxt;

    assign w_data     = r_sync_d[SYNC_STAGES-1];
    assign w_clk_rise = i_en & r_sync_c[SYNC_STAGES-1] & ~r_clk_q;
    assign w_lat_rise = i_en & r_sync_l[SYNC_STAGES-1] & ~r_lat_q;

    // A clk edge coincident with the latch edge is folded into the frame being closed.
    always_comb begin
        w_shift_nxt = r_shift;
        w_count_nxt = o_bit_count;
        if (w_clk_rise) begin
            if (MSB_FIRST != 0) w_shift_nxt = {r_shift[SHIFT_WIDTH-2:0], w_data};
            else                w_shift_nxt = {w_data, r_shift[SHIFT_WIDTH-1:1]};
            if (o_bit_count != MAX_CNT) w_count_nxt = o_bit_count + 1'b1;
        end
        w_commit = w_lat_rise & ((CHECK_LENGTH == 0) || (w_count_nxt == FULL_CNT));
    end

    // Synchronisers and edge registers run regardless of i_en so re-enabling makes no false edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync_d <= '0;
            r_sync_c <= '0;
            r_sync_l <= '0;
            r_clk_q  <= 1'b0;
            r_lat_q  <= 1'b0;
        end else begin
            r_sync_d <= {r_sync_d[SYNC_STAGES-2:0], i_serial_data};
            r_sync_c <= {r_sync_c[SYNC_STAGES-2:0], i_serial_clk};
            r_sync_l <= {r_sync_l[SYNC_STAGES-2:0], i_serial_latch};
            r_clk_q  <= r_sync_c[SYNC_STAGES-1];
            r_lat_q  <= r_sync_l[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= IDLE;
            r_shift         <= '0;
            o_parallel_data <= '0;
            o_valid         <= 1'b0;
            o_frame_err     <= 1'b0;
            o_bit_count     <= '0;
            o_frame_count   <= '0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            if (!i_en) begin
                r_state     <= IDLE;
                o_bit_count <= '0;
            end else begin
                r_shift <= w_shift_nxt;
                if (w_lat_rise) begin
                    r_state     <= IDLE;
                    o_bit_count <= '0;
                    if (w_commit) begin
                        o_parallel_data <= w_shift_nxt;
                        o_valid         <= 1'b1;
                        o_frame_count   <= o_frame_count + 1'b1;
                    end else begin
                        o_frame_err <= 1'b1;
                    end
                end else begin
                    o_bit_count <= w_count_nxt;
                    case (r_state)
                        IDLE:    if (w_clk_rise) r_state <= SHIFT;
                        SHIFT:   if (w_clk_rise && w_count_nxt == MAX_CNT) r_state <= OVER;
                        OVER:    r_state <= OVER;
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
